// File: rtl/lpf_decimator.sv
// lpf_decimator: boxcar decimator for the biquad low-pass filter output.
// Each block of 2^LOG2_R valid samples is summed and floor-divided by the
// block length. Every average is queued in a first-word-fall-through FIFO
// and handed to the consumer over a valid/ready handshake. A sticky flag
// records any average dropped because the FIFO was full.
module lpf_decimator #(
  parameter int unsigned DW         = 32,
  parameter int unsigned LOG2_R     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [DW-1:0]                 in_data,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DW-1:0]                 out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_ovf
);

  localparam int unsigned ACCW = DW + LOG2_R;
  localparam int unsigned CW   = (LOG2_R > 0) ? LOG2_R : 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = AW + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_R) - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic [ACCW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_ovf;

  logic [ACCW-1:0] w_sum;
  logic [DW-1:0]   w_result;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr_en;
  logic            w_drop;

  // Block sum, averaged result and FIFO handshake decodes
  always_comb begin
    w_sum     = r_acc + ACCW'(in_data);
    w_result  = DW'(w_sum >> LOG2_R);
    w_push    = in_valid && (r_cnt == CNT_LAST);
    w_full    = (r_level == LVL_FULL);
    w_pop     = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves at the same edge.
    w_wr_en   = w_push && (!w_full || w_pop);
    w_drop    = w_push && w_full && !w_pop;
  end

  // Accumulate valid samples; restart the block after the last one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (in_valid) begin
      if (r_cnt == CNT_LAST) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // FIFO storage; contents are invalidated by the pointer reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_result;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow; a new drop takes priority over a clear request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // Output view of the FIFO head, forced to zero when empty
  always_comb begin
    out_valid  = (r_level != '0);
    out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    fifo_level = r_level;
    overflow   = r_ovf;
  end

endmodule

// File: doc/lpf_decimator.md
Name: lpf_decimator

Overview:
Output stage placed directly downstream of the biquad low-pass filter (lpf). It takes one filtered 32-bit sample per valid strobe and averages each block of 2^LOG2_R samples (boxcar decimation). Each average is buffered in a small first-word-fall-through FIFO and delivered to the consumer over a valid/ready handshake. Overflow is reported through a sticky flag.

Parameters:
DW, 32, sample width in bits; matches the lpf output width.
LOG2_R, 2, log2 of the decimation ratio R; R = 4 by default; legal range 0..8.
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2, at least 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  synchronous reset, active-low.
in_valid  input  1  in_data carries a new filter sample this cycle.
in_data  input  DW  unsigned filter output sample.
out_ready  input  1  consumer accepts out_data this cycle.
out_valid  output  1  out_data holds a valid decimated sample.
out_data  output  DW  decimated sample (FIFO head).
fifo_level  output  clog2(FIFO_DEPTH)+1  number of entries in the FIFO.
overflow  output  1  sticky flag: a result was dropped because the FIFO was full.
clear_ovf  input  1  clears overflow.

Behaviour:
- Reset (rst_n low at a rising clk edge):
  - Accumulator, sample counter and FIFO pointers go to 0.
  - out_valid=0, out_data=0, fifo_level=0, overflow=0.
  - Reset mid-block discards the partial sum. Reset also discards all FIFO contents.
- Accumulation:
  - Accumulator width is DW+LOG2_R bits and can never wrap.
  - Counter width is max(LOG2_R,1) bits.
  - Edge with in_valid=1 and count<R-1: acc <= acc+in_data; count <= count+1.
  - Edge with in_valid=1 and count==R-1: result = (acc+in_data)>>LOG2_R, a truncating floor that yields the low DW bits; acc <= 0; count <= 0; push result.
  - in_valid=0: no state change. Gaps between samples of any length are allowed.
  - LOG2_R=0: every valid sample is pushed unchanged (pass-through).
- FIFO:
  - First-word-fall-through. A push written at edge N is visible on out_data with out_valid=1 in cycle N+1 when the FIFO was empty. Latency from the last sample of a block to output is therefore 1 cycle.
  - Pop occurs at an edge where out_valid=1 and out_ready=1. out_data then advances to the next entry in the following cycle, or out_valid=0 and out_data=0 if the FIFO becomes empty.
  - When out_valid=0, out_data=0.
  - out_ready while empty is ignored.
  - fifo_level updates at the same edge as the push and/or pop. Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Full:
  - Push while level==FIFO_DEPTH with no pop at the same edge: the result is dropped, FIFO contents are unchanged, and overflow <= 1.
  - Push while full with a pop at the same edge: the push is accepted, the level stays at FIFO_DEPTH, and no overflow is flagged.
- Overflow flag:
  - Sticky. clear_ovf=1 clears it at the next edge.
  - If clear_ovf=1 and a new drop occur at the same edge, set wins and overflow=1.
- Samples are unsigned. No rounding and no saturation beyond the floor shift.
- No combinational path from in_valid/in_data to any output. out_valid and out_data depend only on registered state.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with in_valid=1 and in_data=5 -> out_valid=0, out_data=0, fifo_level=0, overflow=0 throughout. Then release with LOG2_R=2 and send samples 1,2,3,4 -> output 2 (floor of 10/4), proving no residue from the reset period.
2. Averaging (LOG2_R=2): samples 10,20,30,41 on consecutive edges -> exactly one cycle after the 4th edge, out_valid=1 and out_data=25 (101>>2); fifo_level=1. Repeat with 2-cycle in_valid gaps between samples -> same result.
3. Width: four samples of 0xFFFFFFFF -> out_data=0xFFFFFFFF, with no accumulator wrap.
4. Backpressure and overflow: out_ready=0; feed 20 samples whose blocks average to 1,2,3,4,5 -> fifo_level=4, overflow=1, and result 5 is dropped. Then set out_ready=1 -> outputs 1,2,3,4 in order, then out_valid=0. Pulse clear_ovf -> overflow=0.
5. Full with simultaneous pop: fill the FIFO to 4; at the edge that completes a 5th block, assert out_ready=1 -> pop and push both occur, fifo_level stays 4, overflow stays 0, the old head is consumed and the new result sits at the tail.
6. Reset mid-operation: 2 samples of 100, then rst_n=0 for one edge, then 4 samples of 8 -> single output 8. Also assert clear_ovf at the same edge as an overflow drop -> overflow=1.
